// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the parametrised register-file memory:
//   - default word width and depth used when the top is not overridden
//   - state encoding for the walking-clear engine
//   - helper that gives the bit offset of word i on the flat mem bus
// No ports (package).
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // Word i occupies bits [data_w*i +: data_w] of the flat dump bus.
    function automatic int word_offset(input int data_w, input int idx);
        return data_w * idx;
    endfunction

endpackage

// File: rtl/sram_rf_param_word.sv
// ---------------------------------------------------------------------------
// sram_word
// One storage word of the register file: a DATA_W-wide register with
// synchronous reset, a synchronous clear and a load enable.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset, zeroes the word
//   en     in   load enable, captures d
//   clr    in   synchronous clear, zeroes the word (driven by the clear engine)
//   d      in   DATA_W  load data
//   q      out  DATA_W  stored word
// ---------------------------------------------------------------------------
module sram_word
    import sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Reset and the clear engine both zero the word; the clear engine and a
    // write are never active together because writes are blocked while
    // clearing, so the clear-over-load order only matters for robustness.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sram_rf_param.sv
// ---------------------------------------------------------------------------
// sram_rf_param
// Parametrised register-file memory of DEPTH words x DATA_W bits with one
// synchronous write port, one registered read port (latency 1, write-first
// on an address collision), a flat dump of the whole array, and a walking
// clear engine that zeroes one word per cycle.
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   reset       in   synchronous active-high reset
//   we          in   write enable
//   waddr       in   ADDR_W  write address (>= DEPTH is dropped)
//   din         in   DATA_W  write data
//   re          in   read request
//   raddr       in   ADDR_W  read address (>= DEPTH returns 0)
//   dout        out  DATA_W  registered read data, held when no read
//   dout_valid  out  one-cycle strobe marking dout as a fresh read result
//   clr_start   in   pulse that starts the walking clear
//   busy        out  high while the clear engine runs (DEPTH cycles)
//   mem         out  DEPTH*DATA_W  flat array, word i at [DATA_W*i +: DATA_W]
// ADDR_W is derived from DEPTH and is not meant to be overridden.
// ---------------------------------------------------------------------------
module sram_rf_param
    import sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       din,
    input  logic                    re,
    input  logic [ADDR_W-1:0]       raddr,
    output logic [DATA_W-1:0]       dout,
    output logic                    dout_valid,
    input  logic                    clr_start,
    output logic                    busy,
    output logic [DEPTH*DATA_W-1:0] mem
);

    // One extra bit so the range check also works when DEPTH is a power of
    // two (every ADDR_W-bit address is then legal).
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cnt_next;
    logic                clearing;
    logic                waddr_ok;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   words [DEPTH];

    assign clearing = (state == ST_CLEAR);
    assign busy     = clearing;
    assign waddr_ok = ({1'b0, waddr} < DEPTH_EXT);
    assign wr_en    = !clearing && we && waddr_ok;
    assign rd_en    = !clearing && re;

    // Clear-engine state and word counter. Reset abandons a clear in
    // progress and returns to idle with the counter at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic for the clear engine. Termination compares against
    // the last legal index rather than waiting for the counter to wrap, so a
    // non-power-of-two DEPTH stops after exactly DEPTH cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (clr_start) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Read mux over the stored words. An address with no matching word
    // (only possible when DEPTH is not a power of two) yields zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_W'(i)) begin
                rd_word = words[i];
            end
        end
    end

    // Registered read port. A read that collides with a write to the same
    // address returns the incoming data (write-first). With no read, dout
    // keeps its previous value and only the strobe drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_en;
            if (rd_en) begin
                if (wr_en && (waddr == raddr)) begin
                    dout <= din;
                end else begin
                    dout <= rd_word;
                end
            end
        end
    end

    // Storage array: per-word write decode and clear select, plus the flat
    // dump of every word onto the mem bus.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);

        sram_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk   (clk),
            .reset (reset),
            .en    (wr_en && (waddr == IDX)),
            .clr   (clearing && (cnt == IDX)),
            .d     (din),
            .q     (words[i])
        );

        assign mem[word_offset(DATA_W, i) +: DATA_W] = words[i];
    end

endmodule

// File: doc/sram_rf_param.md
Name: sram_rf_param

Overview:
Parametrised register-file memory that generalises the team's fixed 16x32 flop array to DEPTH words of DATA_W bits. It provides:
- one synchronous write port;
- one registered read port with a valid strobe;
- a flat mem dump bus for debug and checkers;
- a sequential walking-clear engine that zeroes the array one word per cycle.

It sits beside the datapath as a scratch/register store and keeps the original's full-array flat output.

Parameters:
DATA_W, 32, bits per word
DEPTH, 16, number of words (any value >= 2; need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived; must not be overridden)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
we  input  1  write enable
waddr  input  ADDR_W  write address
din  input  DATA_W  write data
re  input  1  read request
raddr  input  ADDR_W  read address
dout  output  DATA_W  registered read data
dout_valid  output  1  high for one cycle when dout holds the result of a read
clr_start  input  1  pulse: start walking clear
busy  output  1  high while the clear engine runs
mem  output  DEPTH*DATA_W  flat array; word i at bits [DATA_W*i+DATA_W-1 : DATA_W*i]

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high; sampled only at a rising clk edge.
- Reset values: every word = 0, dout = 0, dout_valid = 0, busy = 0, FSM = IDLE, clear counter = 0. Reset wins over all other inputs in the same cycle, including mid-clear; the clear is abandoned and busy drops next cycle.
- Write:
  - In IDLE, we=1 with waddr < DEPTH updates word[waddr] at the edge.
  - The mem bus reflects the new value the cycle after the edge.
  - waddr >= DEPTH: write silently dropped.
- Read:
  - In IDLE, re=1 gives dout = word[raddr] and dout_valid = 1 on the following cycle (latency 1).
  - re=0: dout_valid = 0 next cycle and dout holds its last value.
  - raddr >= DEPTH: dout = 0, dout_valid = 1.
- Simultaneous read and write to the same address: write-first; dout returns din of that cycle.
- Simultaneous read and write to different addresses: both performed.
- FSM states:
  - IDLE --(clr_start=1)--> CLEAR; counter = 0, busy = 1 from the next cycle.
  - CLEAR: word[counter] = 0 each cycle, counter increments; after word DEPTH-1 is cleared, go to IDLE with busy = 0 the next cycle. Total busy duration = DEPTH cycles exactly.
  - While in CLEAR: we and re are ignored (no write, dout_valid = 0), and clr_start is ignored.
- Same-cycle precedence:
  - clr_start with we in IDLE: the write is performed, then the clear starts next cycle.
  - clr_start with re in IDLE: the read completes (dout_valid next cycle).
- Widths: the counter is ADDR_W bits. Termination compares against DEPTH-1 rather than relying on wrap, so non-power-of-two DEPTH works.

Decomposition:
- Shared package sram_pkg:
  - default DATA_W/DEPTH constants;
  - FSM state enum {ST_IDLE, ST_CLEAR};
  - function for flat-bus word offset (DATA_W*i).
- One sub-module: sram_word, a DATA_W-wide enabled register with synchronous reset and a synchronous clear input, instantiated DEPTH times in a generate loop.
- Address decode, clear FSM and read mux stay in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 3 -> mem[127:96] = 0xDEADBEEF next cycle; every other word = 0.
- Write addr 5 = 0x12345678, next cycle re with raddr=5 -> following cycle dout = 0x12345678, dout_valid = 1 for exactly one cycle.
- Same cycle: we with waddr=7, din=0xA5A5A5A5 and re with raddr=7 (old value 0) -> dout = 0xA5A5A5A5 next cycle (write-first).
- Fill all 16 words with nonzero data, pulse clr_start -> busy high 16 cycles; word k reads 0 after cycle k+1; we/re during busy have no effect; mem = 0 at end.
- Assert reset on cycle 6 of a clear -> busy = 0 and all words = 0 the next cycle; a new clr_start restarts from word 0.
- DEPTH=10, DATA_W=8 build: write to addr 12 is dropped; read of addr 12 gives dout = 0 with valid = 1; clear takes exactly 10 cycles.
